bank_sram_sequencer: RTL and testbench

BANK_SRAM_SEQUENCER -- requirements
Module: bank_sram_sequencer

---
 rtl/bank_sram_sequencer.sv | 240 ++++++++++++++++++++++++
 tb/tb_bank_sram_sequencer.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bank_sram_sequencer.sv
// rtl/bank_sram_sequencer.sv - single-bank SRAM sequencer for write, read, linefill and writeback requests
// One request in flight; every SRAM access is decoded from the FSM state and the offset scan counter.

module ram_sp #(
  parameter int AW = 7,
  parameter int DW = 128
) (
  input  logic          clk_i,
  input  logic          me,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk_i) begin
    if (me) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end
endmodule

module bank_sram_sequencer #(
  parameter int DW    = 128,
  parameter int NOFF  = 2,
  parameter int SW_W  = 6,
  parameter int CH_W  = 2,
  parameter int ROB_W = 3,
  parameter int WB_W  = 8,
  localparam int OFF_W = $clog2(NOFF)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 isu_sc_valid_i,
  output logic                 isu_sc_ready_o,
  input  logic [CH_W-1:0]      isu_sc_channel_id_i,
  input  logic [2:0]           isu_sc_opcode_i,
  input  logic [SW_W-1:0]      isu_sc_set_way_i,
  input  logic [OFF_W-1:0]     isu_sc_offset_i,
  input  logic [WB_W-1:0]      isu_sc_wbuffer_id_i,
  input  logic [ROB_W-1:0]     isu_sc_xbar_rob_num_i,
  input  logic [2*NOFF-1:0]    isu_sc_offset_state_i,
  input  logic [DW*NOFF-1:0]   isu_sc_linefill_data_i,
  output logic                 sc_xbar_valid_o,
  input  logic                 sc_xbar_allowIn_i,
  output logic [CH_W-1:0]      sc_xbar_channel_id_o,
  output logic [ROB_W-1:0]     sc_xbar_rob_num_o,
  output logic [DW-1:0]        sc_xbar_data_o,
  output logic                 sc_biu_valid_o,
  input  logic                 sc_biu_ready_i,
  output logic [DW-1:0]        sc_biu_data_o,
  output logic [SW_W-1:0]      sc_biu_set_way_o,
  output logic [OFF_W-1:0]     sc_biu_offset_o,
  output logic                 sc_biu_last_o,
  output logic                 sc_wbuf_req_valid_o,
  input  logic                 sc_wbuf_req_ready_i,
  output logic [WB_W-1:0]      sc_wbuf_req_wbuffer_id_o,
  input  logic                 sc_wbuf_rtn_valid_i,
  input  logic [DW-1:0]        sc_wbuf_rtn_data_i
);
  localparam int AW = SW_W + OFF_W;
  localparam int CW = OFF_W + 1;
  localparam logic [CW-1:0] CNT_END  = CW'(NOFF);
  localparam logic [CW-1:0] CNT_LAST = CW'(NOFF - 1);

  localparam logic [2:0] OP_WRITE     = 3'd0;
  localparam logic [2:0] OP_READ      = 3'd1;
  localparam logic [2:0] OP_LINEFILL  = 3'd2;
  localparam logic [2:0] OP_WRITEBACK = 3'd3;

  typedef enum logic [3:0] {
    S_IDLE, S_WREQ, S_WWAIT, S_RD, S_RCAP, S_XSEND,
    S_FILL, S_WBRD, S_WBCAP, S_WBSEND, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q;
  logic                 xacc_q;
  logic [CH_W-1:0]      ch_q;
  logic [SW_W-1:0]      sw_q;
  logic [OFF_W-1:0]     off_q;
  logic [WB_W-1:0]      wb_q;
  logic [ROB_W-1:0]     rob_q;
  logic [2*NOFF-1:0]    ost_q;
  logic [DW*NOFF-1:0]   lf_q;
  logic [DW-1:0]        xdata_q, bdata_q;
  logic [OFF_W-1:0]     boff_q;
  logic                 blast_q;

  logic                 accept, scan_live, cur_empty, cur_dirty, more_dirty;
  logic [OFF_W-1:0]     cidx;
  logic [1:0]           cur_st;
  logic                 ram_me, ram_we;
  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_wdata, ram_rdata;

  assign accept    = (state_q == S_IDLE) && isu_sc_valid_i;
  assign cidx      = cnt_q[OFF_W-1:0];
  assign cur_st    = ost_q[2*cidx +: 2];
  assign scan_live = (cnt_q < CNT_END);
  assign cur_empty = scan_live && (cur_st == 2'b00);
  assign cur_dirty = scan_live && (cur_st == 2'b10);

  // last beat of a writeback: nothing dirty strictly above the current offset
  always_comb begin
    more_dirty = 1'b0;
    for (int j = 0; j < NOFF; j++) begin
      if ((CW'(j) > cnt_q) && (ost_q[2*j +: 2] == 2'b10)) more_dirty = 1'b1;
    end
  end

  always_comb begin
    ram_me    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = {sw_q, off_q};
    ram_wdata = sc_wbuf_rtn_data_i;
    case (state_q)
      S_WWAIT: if (sc_wbuf_rtn_valid_i) begin
        ram_me = 1'b1;
        ram_we = 1'b1;
      end
      S_RD: ram_me = 1'b1;
      S_FILL: if (cur_empty) begin
        ram_me    = 1'b1;
        ram_we    = 1'b1;
        ram_addr  = {sw_q, cidx};
        ram_wdata = lf_q[cidx*DW +: DW];
      end
      S_WBRD: if (cur_dirty) begin
        ram_me   = 1'b1;
        ram_addr = {sw_q, cidx};
      end
      default: ;
    endcase
  end

  ram_sp #(.AW(AW), .DW(DW)) u_ram (
    .clk_i (clk_i),
    .me    (ram_me),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (isu_sc_valid_i) begin
        case (isu_sc_opcode_i)
          OP_WRITE:     state_d = S_WREQ;
          OP_READ:      state_d = S_RD;
          OP_LINEFILL:  state_d = S_FILL;
          OP_WRITEBACK: state_d = S_WBRD;
          default:      state_d = S_DONE;
        endcase
      end
      S_WREQ:  if (sc_wbuf_req_ready_i) state_d = S_WWAIT;
      S_WWAIT: if (sc_wbuf_rtn_valid_i) state_d = S_DONE;
      S_RD:    state_d = S_RCAP;
      S_RCAP:  state_d = S_XSEND;
      S_XSEND: if (sc_xbar_allowIn_i) state_d = S_DONE;
      // scan end and xbar acceptance may arrive in either order
      S_FILL:  if ((cnt_q >= CNT_LAST) && (xacc_q || sc_xbar_allowIn_i)) state_d = S_DONE;
      S_WBRD: begin
        if (!scan_live)             state_d = S_DONE;
        else if (cur_dirty)         state_d = S_WBCAP;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_WBCAP:  state_d = S_WBSEND;
      S_WBSEND: if (sc_biu_ready_i) state_d = (cnt_q == CNT_LAST) ? S_DONE : S_WBRD;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      xacc_q  <= 1'b0;
      ch_q    <= '0;
      sw_q    <= '0;
      off_q   <= '0;
      wb_q    <= '0;
      rob_q   <= '0;
      ost_q   <= '0;
      lf_q    <= '0;
      xdata_q <= '0;
      bdata_q <= '0;
      boff_q  <= '0;
      blast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ch_q   <= isu_sc_channel_id_i;
        sw_q   <= isu_sc_set_way_i;
        off_q  <= isu_sc_offset_i;
        wb_q   <= isu_sc_wbuffer_id_i;
        rob_q  <= isu_sc_xbar_rob_num_i;
        ost_q  <= isu_sc_offset_state_i;
        lf_q   <= isu_sc_linefill_data_i;
        cnt_q  <= '0;
        xacc_q <= 1'b0;
        if (isu_sc_opcode_i == OP_LINEFILL)
          xdata_q <= isu_sc_linefill_data_i[isu_sc_offset_i*DW +: DW];
      end
      case (state_q)
        S_RCAP: xdata_q <= ram_rdata;
        S_FILL: begin
          if (scan_live) cnt_q <= cnt_q + 1'b1;
          if (sc_xbar_allowIn_i) xacc_q <= 1'b1;
        end
        S_WBRD: if (scan_live && !cur_dirty) cnt_q <= cnt_q + 1'b1;
        S_WBCAP: begin
          bdata_q <= ram_rdata;
          boff_q  <= cidx;
          blast_q <= !more_dirty;
        end
        S_WBSEND: if (sc_biu_ready_i) cnt_q <= cnt_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign isu_sc_ready_o           = (state_q == S_DONE);
  assign sc_xbar_valid_o          = (state_q == S_XSEND) || ((state_q == S_FILL) && !xacc_q);
  assign sc_xbar_channel_id_o     = ch_q;
  assign sc_xbar_rob_num_o        = rob_q;
  assign sc_xbar_data_o           = xdata_q;
  assign sc_biu_valid_o           = (state_q == S_WBSEND);
  assign sc_biu_data_o            = bdata_q;
  assign sc_biu_set_way_o         = sw_q;
  assign sc_biu_offset_o          = boff_q;
  assign sc_biu_last_o            = blast_q;
  assign sc_wbuf_req_valid_o      = (state_q == S_WREQ);
  assign sc_wbuf_req_wbuffer_id_o = wb_q;
endmodule

// File: tb/tb_bank_sram_sequencer.sv
// tb/tb_bank_sram_sequencer.sv - directed self-checking bench for bank_sram_sequencer
// Main instance uses defaults (NOFF=2, DW=128); a second instance runs NOFF=4, DW=32.

module tb_bank_sram_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic rst = 1'b1;

  logic         valid = 0, ready, allow = 0, xv, bv, b_rdy = 0, wr_v, wr_rdy = 0, rt_v = 0, blast;
  logic [1:0]   ch = 0, xch;
  logic [2:0]   op = 0, rob = 0, xrob;
  logic [5:0]   sw = 0, bsw;
  logic         off = 0, boff;
  logic [7:0]   wbid = 0, wrid;
  logic [3:0]   ost = 0;
  logic [255:0] lfd = 0;
  logic [127:0] xdata, bdata, rt_data = 0;

  logic         valid4 = 0, ready4, allow4 = 0, xv4, bv4, b_rdy4 = 0, wr_v4, wr_rdy4 = 0, rt_v4 = 0, blast4;
  logic [1:0]   ch4 = 0, xch4, off4 = 0, boff4;
  logic [2:0]   op4 = 0, rob4 = 0, xrob4;
  logic [5:0]   sw4 = 0, bsw4;
  logic [7:0]   wbid4 = 0, wrid4, ost4 = 0;
  logic [127:0] lfd4 = 0;
  logic [31:0]  xdata4, bdata4, rt_data4 = 0;

  bank_sram_sequencer dut (
    .clk_i(clk), .rst_i(rst),
    .isu_sc_valid_i(valid), .isu_sc_ready_o(ready),
    .isu_sc_channel_id_i(ch), .isu_sc_opcode_i(op), .isu_sc_set_way_i(sw),
    .isu_sc_offset_i(off), .isu_sc_wbuffer_id_i(wbid), .isu_sc_xbar_rob_num_i(rob),
    .isu_sc_offset_state_i(ost), .isu_sc_linefill_data_i(lfd),
    .sc_xbar_valid_o(xv), .sc_xbar_allowIn_i(allow),
    .sc_xbar_channel_id_o(xch), .sc_xbar_rob_num_o(xrob), .sc_xbar_data_o(xdata),
    .sc_biu_valid_o(bv), .sc_biu_ready_i(b_rdy),
    .sc_biu_data_o(bdata), .sc_biu_set_way_o(bsw), .sc_biu_offset_o(boff), .sc_biu_last_o(blast),
    .sc_wbuf_req_valid_o(wr_v), .sc_wbuf_req_ready_i(wr_rdy), .sc_wbuf_req_wbuffer_id_o(wrid),
    .sc_wbuf_rtn_valid_i(rt_v), .sc_wbuf_rtn_data_i(rt_data)
  );

  bank_sram_sequencer #(.DW(32), .NOFF(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .isu_sc_valid_i(valid4), .isu_sc_ready_o(ready4),
    .isu_sc_channel_id_i(ch4), .isu_sc_opcode_i(op4), .isu_sc_set_way_i(sw4),
    .isu_sc_offset_i(off4), .isu_sc_wbuffer_id_i(wbid4), .isu_sc_xbar_rob_num_i(rob4),
    .isu_sc_offset_state_i(ost4), .isu_sc_linefill_data_i(lfd4),
    .sc_xbar_valid_o(xv4), .sc_xbar_allowIn_i(allow4),
    .sc_xbar_channel_id_o(xch4), .sc_xbar_rob_num_o(xrob4), .sc_xbar_data_o(xdata4),
    .sc_biu_valid_o(bv4), .sc_biu_ready_i(b_rdy4),
    .sc_biu_data_o(bdata4), .sc_biu_set_way_o(bsw4), .sc_biu_offset_o(boff4), .sc_biu_last_o(blast4),
    .sc_wbuf_req_valid_o(wr_v4), .sc_wbuf_req_ready_i(wr_rdy4), .sc_wbuf_req_wbuffer_id_o(wrid4),
    .sc_wbuf_rtn_valid_i(rt_v4), .sc_wbuf_rtn_data_i(rt_data4)
  );

  localparam logic [127:0] PAT_A5 = {16{8'hA5}};
  localparam logic [127:0] PAT_1  = {32{4'h1}};
  localparam logic [127:0] PAT_2  = {32{4'h2}};
  localparam logic [127:0] PAT_3  = {32{4'h3}};
  localparam logic [127:0] PAT_4  = {32{4'h4}};

  task automatic read_check(input logic [5:0] s, input logic o, input logic [1:0] c,
                            input logic [2:0] r, input int stall, input logic [127:0] exp,
                            input string nm);
    int lat;
    valid = 1; op = 3'd1; sw = s; off = o; ch = c; rob = r; allow = 0;
    @(negedge clk);
    lat = 1;
    sw = ~s; off = ~o; ch = ~c; rob = ~r;
    while (!xv && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    n_cmp++;
    if (lat !== 3) begin
      n_bad++;
      $display("FAIL %s_latency: got %0d cycles want 3", nm, lat);
    end
    for (int i = 0; i <= stall; i++) begin
      n_cmp++;
      if (xv !== 1'b1 || xdata !== exp || xch !== c || xrob !== r) begin
        n_bad++;
        $display("FAIL %s_xbar[%0d]: got v=%b d=%h ch=%0d rob=%0d want v=1 d=%h ch=%0d rob=%0d",
                 nm, i, xv, xdata, xch, xrob, exp, c, r);
      end
      if (i == stall) allow = 1;
      @(negedge clk);
    end
    allow = 0;
    n_cmp++;
    if (ready !== 1'b1 || xv !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready: got ready=%b xv=%b want ready=1 xv=0", nm, ready, xv);
    end
    valid = 0;
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b0) begin
      n_bad++;
      $display("FAIL %s_ready_once: got ready=%b want 0", nm, ready);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ready, xv, bv, wr_v} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_valids: got %b want 0000", {ready, xv, bv, wr_v});
    end
    n_cmp++;
    if (xdata !== '0 || bdata !== '0 || wrid !== '0 || xch !== '0 || xrob !== '0 || boff !== 1'b0 || blast !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_payload: got xd=%h bd=%h wrid=%h want all 0", xdata, bdata, wrid);
    end
    n_cmp++;
    if ({ready4, xv4, bv4, wr_v4} !== 4'b0000) begin
      n_bad++;
      $display("FAIL reset_valids_noff4: got %b want 0000", {ready4, xv4, bv4, wr_v4});
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_write();
    valid = 1; op = 3'd0; sw = 6'd5; off = 1'b1; wbid = 8'h3C;
    @(negedge clk);
    n_cmp++;
    if (wr_v !== 1'b1 || wrid !== 8'h3C) begin
      n_bad++;
      $display("FAIL write_req: got v=%b id=%h want v=1 id=3c", wr_v, wrid);
    end
    sw = 6'd0; off = 1'b0; wbid = 8'h00;
    @(negedge clk);
    n_cmp++;
    if (wr_v !== 1'b1 || wrid !== 8'h3C) begin
      n_bad++;
      $display("FAIL write_req_hold: got v=%b id=%h want v=1 id=3c", wr_v, wrid);
    end
    wr_rdy = 1;
    @(negedge clk);
    wr_rdy = 0;
    n_cmp++;
    if (wr_v !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL write_wait: got v=%b ready=%b want 0 0", wr_v, ready);
    end
    rt_v = 1; rt_data = PAT_A5;
    @(negedge clk);
    rt_v = 0; rt_data = '0;
    n_cmp++;
    if (ready !== 1'b1 || xv !== 1'b0 || bv !== 1'b0) begin
      n_bad++;
      $display("FAIL write_ready: got ready=%b xv=%b bv=%b want 1 0 0", ready, xv, bv);
    end
    valid = 0;
    @(negedge clk);
  endtask

  task automatic test_read();
    read_check(6'd5, 1'b1, 2'd2, 3'd5, 3, PAT_A5, "read_stall");
    read_check(6'd5, 1'b1, 2'd1, 3'd3, 0, PAT_A5, "read_nostall");
  endtask

  task automatic test_linefill();
    valid = 1; op = 3'd2; sw = 6'd5; off = 1'b0; ch = 2'd1; rob = 3'd6;
    ost = 4'b1000; lfd = {PAT_1, PAT_2}; allow = 0;
    @(negedge clk);
    n_cmp++;
    if (xv !== 1'b1 || xdata !== PAT_2 || xch !== 2'd1 || xrob !== 3'd6) begin
      n_bad++;
      $display("FAIL lf_xbar: got v=%b d=%h ch=%0d rob=%0d want v=1 d=%h ch=1 rob=6", xv, xdata, xch, xrob, PAT_2);
    end
    lfd = '0; ost = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (xv !== 1'b1 || xdata !== PAT_2) begin
      n_bad++;
      $display("FAIL lf_xbar_hold: got v=%b d=%h want v=1 d=%h", xv, xdata, PAT_2);
    end
    @(negedge clk);
    n_cmp++;
    if (xv !== 1'b1 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL lf_wait_xbar: got xv=%b ready=%b want 1 0", xv, ready);
    end
    allow = 1;
    @(negedge clk);
    allow = 0;
    n_cmp++;
    if (ready !== 1'b1 || xv !== 1'b0) begin
      n_bad++;
      $display("FAIL lf_ready: got ready=%b xv=%b want 1 0", ready, xv);
    end
    valid = 0;
    @(negedge clk);
    read_check(6'd5, 1'b0, 2'd0, 3'd1, 0, PAT_2, "lf_read_off0");
    read_check(6'd5, 1'b1, 2'd0, 3'd2, 0, PAT_A5, "lf_read_off1_old");

    valid = 1; op = 3'd2; sw = 6'd9; off = 1'b1; ost = 4'b0000; lfd = {PAT_3, PAT_4}; allow = 1;
    @(negedge clk);
    n_cmp++;
    if (xv !== 1'b1 || xdata !== PAT_3) begin
      n_bad++;
      $display("FAIL lf2_xbar: got v=%b d=%h want v=1 d=%h", xv, xdata, PAT_3);
    end
    @(negedge clk);
    allow = 0;
    n_cmp++;
    if (xv !== 1'b0 || ready !== 1'b0) begin
      n_bad++;
      $display("FAIL lf2_scan: got xv=%b ready=%b want 0 0", xv, ready);
    end
    @(negedge clk);
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("FAIL lf2_ready: got %b want 1", ready);
    end
    valid = 0;
    @(negedge clk);
    read_check(6'd9, 1'b0, 2'd3, 3'd7, 0, PAT_4, "lf2_read_off0");
  endtask

  task automatic test_writeback();
    int lat;
    valid = 1; op = 3'd3; sw = 6'd5; ost = 4'b1001; b_rdy = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bv && lat < 12);
    n_cmp++;
    if (lat !== 4) begin
      n_bad++;
      $display("FAIL wb_latency: got %0d cycles want 4", lat);
    end
    n_cmp++;
    if (bv !== 1'b1 || bdata !== PAT_A5 || boff !== 1'b1 || blast !== 1'b1 || bsw !== 6'd5 || xv !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_beat: got v=%b d=%h off=%b last=%b sw=%0d xv=%b want v=1 d=%h off=1 last=1 sw=5 xv=0",
               bv, bdata, boff, blast, bsw, xv, PAT_A5);
    end
    @(negedge clk);
    n_cmp++;
    if (bv !== 1'b1 || bdata !== PAT_A5 || boff !== 1'b1 || blast !== 1'b1) begin
      n_bad++;
      $display("FAIL wb_stall_hold: got v=%b d=%h off=%b last=%b want stable beat", bv, bdata, boff, blast);
    end
    b_rdy = 1;
    @(negedge clk);
    b_rdy = 0;
    n_cmp++;
    if (ready !== 1'b1 || bv !== 1'b0) begin
      n_bad++;
      $display("FAIL wb_ready: got ready=%b bv=%b want 1 0", ready, bv);
    end
    valid = 0;
    @(negedge clk);
    for (int t = 0; t < 2; t++) begin
      valid = 1; op = 3'd3; ost = (t == 0) ? 4'b0101 : 4'b1111;
      for (int c = 1; c <= 3; c++) begin
        @(negedge clk);
        n_cmp++;
        if (ready !== (c == 3) || bv !== 1'b0) begin
          n_bad++;
          $display("FAIL wb_nodirty_%0d_c%0d: got ready=%b bv=%b want ready=%b bv=0", t, c, ready, bv, (c == 3));
        end
      end
      valid = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    for (int o = 4; o < 8; o += 3) begin
      valid = 1; op = 3'(o);
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b1 || xv !== 1'b0 || bv !== 1'b0 || wr_v !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_op%0d: got ready=%b xv=%b bv=%b wr=%b want 1 0 0 0", o, ready, xv, bv, wr_v);
      end
      valid = 0;
      @(negedge clk);
      n_cmp++;
      if (ready !== 1'b0) begin
        n_bad++;
        $display("FAIL illegal_op%0d_once: got ready=%b want 0", o, ready);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    valid = 1; op = 3'd3; sw = 6'd5; ost = 4'b1000; b_rdy = 0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bv && lat < 12);
    n_cmp++;
    if (bv !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_wbsend: got bv=%b want 1", bv);
    end
    rst = 1; valid = 0;
    @(negedge clk);
    rst = 0;
    n_cmp++;
    if ({ready, xv, bv, wr_v} !== 4'b0000 || bdata !== '0) begin
      n_bad++;
      $display("FAIL rst_mid_clear: got valids=%b bd=%h want 0000 and 0", {ready, xv, bv, wr_v}, bdata);
    end
    read_check(6'd5, 1'b1, 2'd3, 3'd2, 1, PAT_A5, "rst_mid_read");
  endtask

  task automatic test_noff4();
    logic [31:0] bd [4];
    logic [1:0]  bo [4];
    logic        bl [4];
    logic [31:0] snap_d, xd;
    logic [1:0]  snap_o;
    logic        snap_l, seen, done;
    int          nb, stl;
    valid4 = 1; op4 = 3'd2; sw4 = 6'd3; off4 = 2'd0; ost4 = 8'h00; allow4 = 1;
    lfd4 = {32'hDDDD0003, 32'hDDDD0002, 32'hDDDD0001, 32'hDDDD0000};
    seen = 0; done = 0; xd = '0;
    for (int cyc = 0; cyc < 20 && !done; cyc++) begin
      @(negedge clk);
      if (xv4 && !seen) begin
        seen = 1;
        xd = xdata4;
      end
      if (ready4) done = 1;
    end
    valid4 = 0; allow4 = 0;
    n_cmp++;
    if (!done || !seen || xd !== 32'hDDDD0000) begin
      n_bad++;
      $display("FAIL noff4_fill: got done=%b seen=%b d=%h want 1 1 dddd0000", done, seen, xd);
    end
    @(negedge clk);

    valid4 = 1; op4 = 3'd3; ost4 = 8'h66; b_rdy4 = 0;
    nb = 0; stl = 0; done = 0;
    snap_d = '0; snap_o = '0; snap_l = 0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      b_rdy4 = 0;
      if (ready4) begin
        done = 1;
        valid4 = 0;
      end else if (bv4) begin
        if (stl == 0) begin
          snap_d = bdata4; snap_o = boff4; snap_l = blast4;
        end else begin
          n_cmp++;
          if (bdata4 !== snap_d || boff4 !== snap_o || blast4 !== snap_l || bsw4 !== 6'd3) begin
            n_bad++;
            $display("FAIL noff4_stall_hold: got d=%h off=%0d last=%b want d=%h off=%0d last=%b",
                     bdata4, boff4, blast4, snap_d, snap_o, snap_l);
          end
        end
        if (stl == 2) begin
          b_rdy4 = 1;
          if (nb < 4) begin
            bd[nb] = bdata4; bo[nb] = boff4; bl[nb] = blast4;
          end
          nb++;
          stl = 0;
        end else begin
          stl++;
        end
      end
    end
    valid4 = 0;
    @(negedge clk);
    n_cmp++;
    if (!done || nb !== 2) begin
      n_bad++;
      $display("FAIL noff4_beats: got done=%b beats=%0d want done=1 beats=2", done, nb);
    end
    if (nb >= 2) begin
      n_cmp++;
      if (bo[0] !== 2'd0 || bd[0] !== 32'hDDDD0000 || bl[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL noff4_beat0: got off=%0d d=%h last=%b want off=0 d=dddd0000 last=0", bo[0], bd[0], bl[0]);
      end
      n_cmp++;
      if (bo[1] !== 2'd2 || bd[1] !== 32'hDDDD0002 || bl[1] !== 1'b1) begin
        n_bad++;
        $display("FAIL noff4_beat1: got off=%0d d=%h last=%b want off=2 d=dddd0002 last=1", bo[1], bd[1], bl[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_linefill();
    test_writeback();
    test_illegal();
    test_reset_mid();
    test_noff4();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
